// File: rtl/isp_demosaic_ctrl.sv
// Frame sequencer in front of the Bayer demosaic: re-times the raw stream, enforces
// frame geometry, injects flush lines after the last real line and tracks errors.
module isp_demosaic_ctrl #(
  parameter int BITS        = 8,
  parameter int WIDTH       = 1280,
  parameter int HEIGHT      = 960,
  parameter int FLUSH_LINES = 2,
  parameter int FLUSH_GAP   = 64
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic            in_de,
  input  logic [BITS-1:0] in_raw,
  input  logic            cfg_enable,
  input  logic [1:0]      cfg_bayer,
  input  logic            err_clr,
  output logic            out_href,
  output logic            out_vsync,
  output logic            out_de,
  output logic [BITS-1:0] out_raw,
  output logic [1:0]      act_bayer,
  output logic            frame_done,
  output logic [15:0]     frame_cnt,
  output logic            err_short,
  output logic            err_long,
  output logic            err_lines,
  output logic            busy
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam int LW = $clog2(HEIGHT + 1);
  localparam int GW = $clog2(FLUSH_GAP + 1);
  localparam int FW = $clog2(FLUSH_LINES + 1);

  localparam logic [PW-1:0] PIX_FULL   = PW'(WIDTH);
  localparam logic [LW-1:0] LINE_LAST  = LW'(HEIGHT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(FLUSH_GAP - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_LINES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACTIVE = 3'd1;
  localparam logic [2:0] S_SKIP   = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]    state;
  logic          vsync_d;
  logic          href_d;
  logic [PW-1:0] pix_cnt;
  logic [LW-1:0] line_cnt;
  logic [GW-1:0] gap_cnt;
  logic [FW-1:0] flush_cnt;
  logic          frame_start;
  logic          vsync_rise;
  logic          line_end;

  assign frame_start = vsync_d & ~in_vsync;
  assign vsync_rise  = ~vsync_d & in_vsync;
  assign line_end    = href_d & ~in_href;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      vsync_d    <= 1'b0;
      href_d     <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      gap_cnt    <= '0;
      flush_cnt  <= '0;
      out_href   <= 1'b0;
      out_vsync  <= 1'b0;
      out_de     <= 1'b0;
      out_raw    <= '0;
      act_bayer  <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_lines  <= 1'b0;
    end else begin
      vsync_d    <= in_vsync;
      href_d     <= in_href;
      out_vsync  <= in_vsync;
      out_href   <= 1'b0;
      out_de     <= 1'b0;
      out_raw    <= '0;
      frame_done <= 1'b0;
      // clear first; any later set in this cycle overrides it
      err_short  <= err_short & ~err_clr;
      err_long   <= err_long  & ~err_clr;
      err_lines  <= err_lines & ~err_clr;

      if (frame_start) begin
        act_bayer <= cfg_bayer;
        state     <= cfg_enable ? S_ACTIVE : S_SKIP;
        pix_cnt   <= '0;
        line_cnt  <= '0;
        gap_cnt   <= '0;
        flush_cnt <= '0;
      end else begin
        case (state)
          S_ACTIVE: begin
            if (vsync_rise) begin
              err_lines <= 1'b1;
              state     <= S_IDLE;
            end else if (in_href) begin
              if (pix_cnt < PIX_FULL) begin
                out_href <= 1'b1;
                out_de   <= in_de;
                out_raw  <= in_raw;
                pix_cnt  <= pix_cnt + 1'b1;
              end else begin
                err_long <= 1'b1;
              end
            end else begin
              out_de  <= in_de;
              out_raw <= in_raw;
              if (line_end) begin
                if (pix_cnt < PIX_FULL) err_short <= 1'b1;
                pix_cnt  <= '0;
                line_cnt <= line_cnt + 1'b1;
                if (line_cnt == LINE_LAST) begin
                  state   <= S_GAP;
                  gap_cnt <= '0;
                end
              end
            end
          end
          S_GAP, S_FLUSH: begin
            if (vsync_rise) begin
              err_lines <= 1'b1;
              state     <= S_IDLE;
            end else begin
              if (in_href) err_lines <= 1'b1;
              if (state == S_GAP) begin
                // the last gap cycle already launches the first flush pixel
                if (gap_cnt == GAP_LAST) begin
                  state    <= S_FLUSH;
                  out_href <= 1'b1;
                  out_de   <= 1'b1;
                  pix_cnt  <= PW'(1);
                end else begin
                  gap_cnt <= gap_cnt + 1'b1;
                end
              end else if (pix_cnt < PIX_FULL) begin
                out_href <= 1'b1;
                out_de   <= 1'b1;
                pix_cnt  <= pix_cnt + 1'b1;
              end else begin
                pix_cnt   <= '0;
                flush_cnt <= flush_cnt + 1'b1;
                if (flush_cnt == FLUSH_LAST) begin
                  state      <= S_DONE;
                  frame_done <= 1'b1;
                end else begin
                  state   <= S_GAP;
                  gap_cnt <= '0;
                end
              end
            end
          end
          S_DONE: begin
            frame_cnt <= frame_cnt + 1'b1;
            state     <= S_IDLE;
          end
          S_SKIP: begin
            if (vsync_rise) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_isp_demosaic_ctrl.sv
// Directed bench for isp_demosaic_ctrl: table-driven nominal frame plus hand-written
// sequences for length errors, early vsync, config latch, skip, error clear and reset.
module tb_isp_demosaic_ctrl;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int FL = 2;
  localparam int G  = 4;

  logic       pclk;
  logic       rst_n;
  logic       in_href;
  logic       in_vsync;
  logic       in_de;
  logic [7:0] in_raw;
  logic       cfg_enable;
  logic [1:0] cfg_bayer;
  logic       err_clr;
  logic       out_href;
  logic       out_vsync;
  logic       out_de;
  logic [7:0] out_raw;
  logic [1:0] act_bayer;
  logic       frame_done;
  logic [15:0] frame_cnt;
  logic       err_short;
  logic       err_long;
  logic       err_lines;
  logic       busy;

  isp_demosaic_ctrl #(
    .BITS(8), .WIDTH(W), .HEIGHT(H), .FLUSH_LINES(FL), .FLUSH_GAP(G)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
    .in_de(in_de), .in_raw(in_raw), .cfg_enable(cfg_enable), .cfg_bayer(cfg_bayer),
    .err_clr(err_clr), .out_href(out_href), .out_vsync(out_vsync), .out_de(out_de),
    .out_raw(out_raw), .act_bayer(act_bayer), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .err_short(err_short), .err_long(err_long),
    .err_lines(err_lines), .busy(busy)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       href;
    logic [7:0] raw;
    logic       vsync;
    logic       e_href;
    logic [7:0] e_raw;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   exp_frames = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic void add(input logic h, input logic [7:0] r, input logic v,
                              input logic eh, input logic [7:0] er, input logic ed);
    vec_t t;
    t.href = h; t.raw = r; t.vsync = v; t.e_href = eh; t.e_raw = er; t.e_done = ed;
    vecs.push_back(t);
  endfunction

  // Each step applies inputs for one cycle and returns #1 after the edge that registers them.
  task automatic step(input logic h, input logic [7:0] r, input logic v);
    in_href = h; in_de = h; in_raw = r; in_vsync = v;
    @(posedge pclk);
    #1;
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      step(vecs[i].href, vecs[i].raw, vecs[i].vsync);
      chk($sformatf("tbl[%0d] href", i), out_href, vecs[i].e_href);
      chk($sformatf("tbl[%0d] de", i), out_de, vecs[i].e_href);
      chk($sformatf("tbl[%0d] raw", i), out_raw, vecs[i].e_raw);
      chk($sformatf("tbl[%0d] vsync", i), out_vsync, vecs[i].vsync);
      chk($sformatf("tbl[%0d] done", i), frame_done, vecs[i].e_done);
    end
  endtask

  task automatic frame_start(input logic en, input logic [1:0] b);
    cfg_enable = en;
    cfg_bayer  = b;
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("fs act_bayer", act_bayer, b);
    chk("fs busy", busy, 1);
  endtask

  task automatic send_line(input int n, input int base, input logic en, input logic clr_end);
    for (int i = 0; i < n; i++) begin
      step(1, 8'(base + i), 0);
      chk("line href", out_href, (en && i < W));
      chk("line raw", out_raw, (en && i < W) ? base + i : 0);
    end
    err_clr = clr_end;
    step(0, 0, 0);
    err_clr = 1'b0;
    chk("line end href", out_href, 0);
    step(0, 0, 0);
    chk("line idle href", out_href, 0);
  endtask

  task automatic wait_done();
    int pix;
    int done;
    logic [7:0] raw_or;
    pix = 0; done = 0; raw_or = '0;
    for (int c = 0; c < 100 && done == 0; c++) begin
      step(0, 0, 0);
      if (out_href) begin
        pix++;
        raw_or = raw_or | out_raw;
      end
      if (frame_done) done++;
    end
    chk("flush pixels", pix, FL * W);
    chk("flush raw", raw_or, 0);
    chk("frame_done seen", done, 1);
    step(0, 0, 0);
    chk("frame_done width", frame_done, 0);
    exp_frames++;
    chk("frame_cnt", frame_cnt, exp_frames);
    chk("busy after done", busy, 0);
  endtask

  task automatic chk_errs(input logic s, input logic l, input logic ln);
    chk("err_short", err_short, s);
    chk("err_long", err_long, l);
    chk("err_lines", err_lines, ln);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step(0, 0, in_vsync);
    err_clr = 1'b0;
  endtask

  initial begin
    int cnt_href;
    int cnt_done;
    int found;

    rst_n = 1'b0; in_href = 0; in_vsync = 0; in_de = 0; in_raw = '0;
    cfg_enable = 1'b1; cfg_bayer = 2'd0; err_clr = 1'b0;

    // Nominal frame table: vsync pulse, 4 lines of 8 pixels (1..32), two gap+flush lines.
    add(0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    for (int l = 0; l < H; l++) begin
      for (int p = 0; p < W; p++) add(1, 8'(l * W + p + 1), 0, 1, 8'(l * W + p + 1), 0);
      if (l < H - 1) begin
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
      end
    end
    for (int f = 0; f < FL; f++) begin
      for (int g = 0; g < G; g++) add(0, 0, 0, 0, 0, 0);
      for (int p = 0; p < W; p++) add(0, 0, 0, 1, 0, 0);
    end
    add(0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge pclk);
    #1;
    chk("rst out_href", out_href, 0);
    chk("rst out_vsync", out_vsync, 0);
    chk("rst out_de", out_de, 0);
    chk("rst out_raw", out_raw, 0);
    chk("rst act_bayer", act_bayer, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst frame_cnt", frame_cnt, 0);
    chk("rst busy", busy, 0);
    chk_errs(0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0);

    // 1: nominal frame
    run_table();
    exp_frames = 1;
    chk("nominal frame_cnt", frame_cnt, exp_frames);
    chk("nominal busy", busy, 0);
    chk_errs(0, 0, 0);

    // 2: short line 2 and long line 3
    frame_start(1, 0);
    send_line(8, 1, 1, 0);
    send_line(6, 9, 1, 0);
    send_line(10, 15, 1, 0);
    send_line(8, 25, 1, 0);
    wait_done();
    chk_errs(1, 1, 0);

    // 3: early vsync after two lines
    pulse_clr();
    chk_errs(0, 0, 0);
    frame_start(1, 0);
    send_line(8, 1, 1, 0);
    send_line(8, 9, 1, 0);
    step(0, 0, 1);
    chk_errs(0, 0, 1);
    chk("early busy", busy, 0);
    cnt_href = 0; cnt_done = 0;
    for (int c = 0; c < 30; c++) begin
      step(0, 0, 1);
      if (out_href) cnt_href++;
      if (frame_done) cnt_done++;
    end
    chk("early flush href", cnt_href, 0);
    chk("early frame_done", cnt_done, 0);
    chk("early frame_cnt", frame_cnt, exp_frames);

    // 4: bayer latched at frame start only
    pulse_clr();
    frame_start(1, 3);
    send_line(8, 1, 1, 0);
    cfg_bayer = 2'd1;
    send_line(8, 9, 1, 0);
    chk("mid act_bayer", act_bayer, 3);
    chk("mid busy", busy, 1);
    send_line(8, 17, 1, 0);
    send_line(8, 25, 1, 0);
    wait_done();
    chk("post act_bayer", act_bayer, 3);

    // 5: skipped frame, then a nominal one
    frame_start(0, 1);
    for (int l = 0; l < H; l++) send_line(W, l * W + 1, 0, 0);
    step(0, 0, 1);
    chk("skip busy", busy, 0);
    chk("skip frame_cnt", frame_cnt, exp_frames);
    chk_errs(0, 0, 0);
    cfg_enable = 1'b1;
    run_table();
    exp_frames++;
    chk("after skip frame_cnt", frame_cnt, exp_frames);
    chk("after skip act_bayer", act_bayer, 1);

    // 6: err_clr coincident with a short line, then reset during flush
    pulse_clr();
    frame_start(1, 2);
    send_line(6, 1, 1, 1);
    chk("clr+set err_short", err_short, 1);
    pulse_clr();
    chk("clr err_short", err_short, 0);
    send_line(8, 9, 1, 0);
    send_line(8, 17, 1, 0);
    send_line(8, 25, 1, 0);
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      step(0, 0, 0);
      if (out_href) found = 1;
    end
    chk("flush reached", found, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst out_href", out_href, 0);
    chk("arst out_de", out_de, 0);
    chk("arst out_raw", out_raw, 0);
    chk("arst out_vsync", out_vsync, 0);
    chk("arst act_bayer", act_bayer, 0);
    chk("arst frame_cnt", frame_cnt, 0);
    chk("arst busy", busy, 0);
    chk_errs(0, 0, 0);
    @(posedge pclk);
    #1 rst_n = 1'b1;
    exp_frames = 0;
    for (int c = 0; c < 5; c++) step(0, 0, 0);
    chk("post rst href", out_href, 0);
    chk("post rst busy", busy, 0);
    run_table();
    exp_frames++;
    chk("post rst frame_cnt", frame_cnt, exp_frames);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/isp_demosaic_ctrl.md
# isp_demosaic_ctrl

Frame sequencer placed directly in front of the Bayer demosaic (`isp_demosaic_m`) in the HDMI ISP path. It re-times the sensor raw stream into the demosaic and enforces the configured frame geometry, trimming long lines and dropping surplus lines. After the last real line of each frame it injects flush lines, so the demosaic's line-buffer and pipeline latency drains the bottom rows of the frame. It also latches per-frame configuration at frame start, keeps sticky geometry-error flags and counts completed frames.

## Interface
- `BITS`, 8, raw pixel width
- `WIDTH`, 1280, active pixels per line
- `HEIGHT`, 960, active lines per frame
- `FLUSH_LINES`, 2, synthetic lines injected after line `HEIGHT`
- `FLUSH_GAP`, 64, idle (href-low) cycles before each flush line; must be ≥1
- `pclk` in 1 — pixel clock, single clock domain
- `rst_n` in 1 — asynchronous, active-low reset
- `in_href` in 1 — sensor line valid
- `in_vsync` in 1 — sensor vsync, active high; frame starts on its falling edge
- `in_de` in 1 — sensor data enable, passed through with href
- `in_raw` in BITS — sensor pixel
- `cfg_enable` in 1 — process frames; sampled at frame start
- `cfg_bayer` in 2 — 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR; sampled at frame start
- `err_clr` in 1 — one-cycle pulse; clears all sticky errors
- `out_href`, `out_vsync`, `out_de` out 1 each — stream to demosaic
- `out_raw` out BITS — pixel to demosaic
- `act_bayer` out 2 — Bayer pattern latched for the current frame
- `frame_done` out 1 — one-cycle pulse at the end of the last flush line
- `frame_cnt` out 16 — completed frames, wraps at 0xFFFF→0
- `err_short`, `err_long`, `err_lines` out 1 each — sticky error flags
- `busy` out 1 — high when the FSM is not in IDLE

## Operation
- FSM states: IDLE, ACTIVE, SKIP, GAP, FLUSH, DONE.
- Frame start is an `in_vsync` falling edge (1→0 across consecutive cycles), detected in any state.
  - On frame start: latch `cfg_bayer` into `act_bayer` and sample `cfg_enable`.
  - If `cfg_enable`=1, go to ACTIVE; otherwise go to SKIP.
  - Clear line, pixel and flush counters.
  - `act_bayer` changes only at frame start.
- IDLE and SKIP:
  - Force `out_href`, `out_de` and `out_raw` to 0.
  - `out_vsync` follows `in_vsync`.
  - SKIP stays in SKIP until the next frame start or until `in_vsync` rises, which returns it to IDLE.
- ACTIVE, pass-through:
  - `out_*` = `in_*` registered one cycle.
  - `pix_cnt` counts `in_href`-high cycles in the current line.
  - Pixels with `pix_cnt` ≥ WIDTH are suppressed (`out_href`/`out_de`/`out_raw` forced 0) and set `err_long`.
- ACTIVE, line end (`in_href` falling edge):
  - If `pix_cnt` < WIDTH, set `err_short`.
  - Increment `line_cnt` and clear `pix_cnt`.
  - When `line_cnt` reaches HEIGHT, go to GAP.
- ACTIVE, early vsync: `in_vsync` rising while `line_cnt` < HEIGHT sets `err_lines` and returns to IDLE with no flush.
- GAP: hold `out_href`=0 for FLUSH_GAP cycles, then go to FLUSH.
- FLUSH:
  - Drive `out_href`=`out_de`=1 with `out_raw`=0 for exactly WIDTH cycles.
  - Then increment `flush_cnt`: go to GAP if `flush_cnt` < FLUSH_LINES, else go to DONE.
- Input `in_href` during GAP or FLUSH is a surplus line:
  - Set `err_lines`.
  - The input pixels are discarded; the synthetic stream is unaffected.
- `in_vsync` rising during GAP or FLUSH:
  - Set `err_lines`, go to IDLE, and drop `out_href` on the next cycle (a partial flush line is allowed).
  - No `frame_done` is issued.
- DONE: pulse `frame_done` for one cycle, increment `frame_cnt`, go to IDLE.
- `out_vsync` is always `in_vsync` delayed one cycle.
- Sticky errors:
  - Set by the events above; cleared by `err_clr`.
  - If a set event and `err_clr` occur in the same cycle, set wins.
- Counter widths are `$clog2(WIDTH+1)` for pixels and `$clog2(HEIGHT+1)` for lines.
  - `pix_cnt` saturates at WIDTH, so it cannot wrap on over-long lines.

## Timing
- Reset: all outputs 0, FSM in IDLE, `act_bayer`=0, all counters 0.
- Pass-through latency is 1 cycle for href, vsync, de and raw alike.
- The first FLUSH pixel appears FLUSH_GAP+1 cycles after the `in_href` falling edge of line HEIGHT (1 registered cycle plus the GAP count).
- The frame sequence is HEIGHT real lines followed by FLUSH_LINES×(FLUSH_GAP+WIDTH) synthetic cycles.
- `frame_done` is asserted in the cycle after the last flush pixel.
- `busy` is registered with the state and is 0 in IDLE only.
- Reset asserted mid-frame: all outputs are 0 asynchronously; after release the block waits in IDLE for the next frame start.

## Test plan
Parameters for all scenarios: WIDTH=8, HEIGHT=4, FLUSH_LINES=2, FLUSH_GAP=4.

1. **Nominal frame.** Stimulus: frame start, then 4 lines of 8 pixels with values 1..32. Required: identical `out_raw` delayed 1 cycle; two 8-cycle zero lines after 4-cycle gaps; `frame_done` pulsed once; `frame_cnt`=1; no errors.
2. **Line length errors.** Stimulus: line 2 has 6 pixels and line 3 has 10 pixels. Required: `err_short`=1 and `err_long`=1; line 3 pixels 9–10 are not output (`out_href`=0).
3. **Early vsync.** Stimulus: vsync rises after 2 lines. Required: `err_lines`=1, no flush lines, no `frame_done`, `busy`=0.
4. **Config latch.** Stimulus: `cfg_bayer`=3 at frame start, changed to 1 mid-frame. Required: `act_bayer`=3 until the next frame start, then `act_bayer`=1.
5. **Frame skip.** Stimulus: `cfg_enable`=0 at frame start. Required: `out_href` stays 0 for the whole frame and `frame_cnt` is unchanged; with `cfg_enable`=1 the next frame runs nominally.
6. **Error clear and async reset.** Stimulus: `err_clr` in the same cycle as a short line. Required: `err_short` ends at 1. Stimulus: async reset during FLUSH. Required: all outputs 0 immediately.
